// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_GROUP = 4;

  // Per-bit propagate/generate for one lookahead group.
  typedef struct packed {
    logic [CLA_GROUP-1:0] p;
    logic [CLA_GROUP-1:0] g;
  } pg_t;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: carry out of every bit from P/G and the group carry-in.
module cla_group4
  import cla_pkg::*;
(
  input  pg_t                  pg_i,
  input  logic                 c_i,
  output logic [CLA_GROUP-1:0] c_o
);

  logic [CLA_GROUP-1:0] p;
  logic [CLA_GROUP-1:0] g;

  assign p = pg_i.p;
  assign g = pg_i.g;

  assign c_o[0] = g[0] | (p[0] & c_i);
  assign c_o[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c_o[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
  assign c_o[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                  (p[3] & p[2] & p[1] & p[0] & c_i);

endmodule

// File: rtl/cla_pipe_adder16.sv
// Two-stage valid/ready carry-lookahead adder: stage 1 registers P/G, stage 2 registers the sum.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder16
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned NGRP = WIDTH / CLA_GROUP;

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : gen_width_check
    $error("cla_pipe_adder16: WIDTH must be a multiple of 4 in 4..64");
  end

  logic                  s1_valid_q;
  pg_t [NGRP-1:0]        pg_q;
  pg_t [NGRP-1:0]        pg_d;
  logic                  cin_q;

  logic                  s2_valid_q;
  logic                  s2_advance;
  logic [WIDTH-1:0]      sum_q;
  logic                  cout_q;
`ifdef CLA_PIPE_OVF_EN
  logic                  ovf_q;
`endif

  logic [WIDTH-1:0]      p_vec;
  logic [WIDTH-1:0]      co_vec;
  logic [WIDTH-1:0]      carry_in;

  // No skid buffer: upstream ready depends combinationally on out_ready.
  assign s2_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;

  for (genvar gi = 0; gi < NGRP; gi++) begin : gen_grp
    logic grp_cin;

    assign pg_d[gi].p = a[gi*CLA_GROUP +: CLA_GROUP] ^ b[gi*CLA_GROUP +: CLA_GROUP];
    assign pg_d[gi].g = a[gi*CLA_GROUP +: CLA_GROUP] & b[gi*CLA_GROUP +: CLA_GROUP];
    assign p_vec[gi*CLA_GROUP +: CLA_GROUP] = pg_q[gi].p;

    // Group carries ripple from one lookahead group to the next.
    if (gi == 0) begin : gen_first
      assign grp_cin = cin_q;
    end else begin : gen_rest
      assign grp_cin = co_vec[gi*CLA_GROUP-1];
    end

    cla_group4 u_grp (
      .pg_i (pg_q[gi]),
      .c_i  (grp_cin),
      .c_o  (co_vec[gi*CLA_GROUP +: CLA_GROUP])
    );
  end

  assign carry_in = {co_vec[WIDTH-2:0], cin_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      pg_q       <= '0;
      cin_q      <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        pg_q  <= pg_d;
        cin_q <= cin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
      ovf_q      <= 1'b0;
`endif
    end else if (s2_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q  <= p_vec ^ carry_in;
        cout_q <= co_vec[WIDTH-1];
`ifdef CLA_PIPE_OVF_EN
        ovf_q  <= co_vec[WIDTH-2] ^ co_vec[WIDTH-1];
`endif
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder16.sv
// Self-checking bench for cla_pipe_adder16: vector table, backpressure, reset and random streams.
module tb_cla_pipe_adder16;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        v;
    int          t;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [15:0] a, b, sum;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  exp_t        sb[$];
  exp_t        nul;
  int          n_chk = 0;
  int          n_err = 0;
  int          tick_n = 0;
  int          n_acc = 0;

  always #5 clk = ~clk;

  cla_pipe_adder16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  cla_pipe_adder16 #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
`ifdef CLA_PIPE_OVF_EN
    .ovf       (ovf4),
`endif
    .cout      (cout4)
  );

`ifndef CLA_PIPE_OVF_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
`endif

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", nm, act, exp_v, tick_n);
    end
  endfunction

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] s;
    exp_t        e;
    s   = {1'b0, x} + {1'b0, y} + {16'b0, c};
    e.s = s[15:0];
    e.c = s[16];
    e.v = (x[15] == y[15]) && (s[15] != x[15]);
    e.t = 0;
    return e;
  endfunction

  // One cycle: drive on the falling edge, then score the handshakes the next rising edge takes.
  task automatic tick(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic ordy, input exp_t ex, input bit lat);
    exp_t got;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        got = sb.pop_front();
        chk("sum", 64'(sum), 64'(got.s));
        chk("cout", 64'(cout), 64'(got.c));
`ifdef CLA_PIPE_OVF_EN
        chk("ovf", 64'(ovf), 64'(got.v));
`endif
        if (lat) chk("latency", 64'(tick_n - got.t), 64'(2));
      end
    end
    if (in_valid && in_ready) begin
      ex.t = tick_n;
      sb.push_back(ex);
      n_acc++;
    end
    tick_n++;
  endtask

  task automatic drain(input bit lat);
    for (int n = 0; n < 12 && sb.size() > 0; n++) tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, nul, lat);
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_chk);
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int   acc0;
    exp_t e;
    logic [15:0] ra, rb;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};
    nul = '{16'h0, 1'b0, 1'b0, 0};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_out_valid4", 64'(out_valid4), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=4 instance: 0xF + 0x1 wraps to 0 with carry out, two cycles after acceptance
    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
    #1;
    chk("w4_in_ready", 64'(in_ready4), 64'(1));
    @(negedge clk);
    in_valid4 = 1'b0;
    #1;
    chk("w4_early_valid", 64'(out_valid4), 64'(0));
    @(negedge clk);
    #1;
    chk("w4_out_valid", 64'(out_valid4), 64'(1));
    chk("w4_sum", 64'(sum4), 64'(0));
    chk("w4_cout", 64'(cout4), 64'(1));

    // Table vectors streamed back to back with out_ready held high
    for (int i = 0; i < 8; i++) begin
      e = '{tbl[i].s, tbl[i].c, tbl[i].v, 0};
      tick(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1, e, 1'b1);
    end
    drain(1'b1);

    // Backpressure: three operands while out_ready is low for four cycles
    acc0 = n_acc;
    tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0), 1'b0);
    tick(1'b1, 16'hF000, 16'h1000, 1'b0, 1'b0, model(16'hF000, 16'h1000, 1'b0), 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 16'h0001, 16'h0001, 1'b1, 1'b0, model(16'h0001, 16'h0001, 1'b1), 1'b0);
      chk("bp_in_ready_low", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_hold_sum", 64'(sum), 64'(16'h3333));
      chk("bp_hold_cout", 64'(cout), 64'(0));
    end
    tick(1'b1, 16'h0001, 16'h0001, 1'b1, 1'b1, model(16'h0001, 16'h0001, 1'b1), 1'b0);
    drain(1'b0);
    chk("bp_accepted", 64'(n_acc - acc0), 64'(3));

    // Reset with two results in flight
    tick(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0, model(16'h0102, 16'h0304, 1'b0), 1'b0);
    tick(1'b1, 16'h0506, 16'h0708, 1'b1, 1'b0, model(16'h0506, 16'h0708, 1'b1), 1'b0);
    tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, nul, 1'b0);
    chk("mid_out_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_sum", 64'(sum), 64'(0));
    chk("mid_rst_cout", 64'(cout), 64'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, nul, 1'b0);
      chk("post_rst_idle", 64'(out_valid), 64'(0));
    end
    tick(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b1, model(16'h4000, 16'h4000, 1'b0), 1'b1);
    drain(1'b1);

    // Random operands with random valid/ready
    acc0 = n_acc;
    for (int n = 0; n < 40000 && (n_acc - acc0) < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      e  = model(ra, rb, cin);
      tick(($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0),
           nul, 1'b0);
      // The model is evaluated after the drive so it sees the cin actually presented.
      if (sb.size() > 0 && in_valid && in_ready) begin
        e = model(a, b, cin);
        e.t = sb[sb.size()-1].t;
        sb[sb.size()-1] = e;
      end
    end
    drain(1'b0);
    chk("rand_accepted", 64'(n_acc - acc0), 64'(10000));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder16.md
CLA_PIPE_ADDER16 -- requirements
Module: cla_pipe_adder16

Interface
REQ-001 SHALL have parameter WIDTH, default 16; operand/sum width; legal values are multiples of 4 in the range 4..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream operand valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have ports a, b  input  WIDTH  unsigned/two's-complement operands.
REQ-007 SHALL have port cin  input  1  carry-in.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port sum  output  WIDTH  a+b+cin, low WIDTH bits.
REQ-011 SHALL have port cout  output  1  carry out of the MSB.

Function
REQ-012 Transfer SHALL occur on a valid&ready cycle, at the input and output independently.
REQ-013 Stage 1 SHALL register per-bit P=a^b, G=a&b, cin and a stage-valid flag.
REQ-014 Stage 2 SHALL compute 4-bit group carries from the registered P/G by lookahead, ripple group carry between groups, and register sum=P^{carry vector}, cout and a stage-valid flag.
REQ-015 Latency SHALL be exactly 2 cycles from input acceptance to out_valid when out_ready is held 1; throughput SHALL be 1 result per cycle.
REQ-016 Each stage SHALL advance when it is empty or its contents are taken this cycle; in_ready = !s1_valid | s2_advance (combinational from out_ready, no skid buffer).
REQ-017 While out_valid=1 and out_ready=0, sum/cout/out_valid SHALL be held stable, and no accepted operand SHALL be lost or duplicated.
REQ-018 Results SHALL emerge in acceptance order.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH with cout = bit WIDTH of the full sum; e.g. 0xFFFF+0x0000+1 -> sum 0x0000, cout 1.
REQ-020 Simultaneous output drain and input accept with both stages full SHALL shift the pipeline without a bubble.
REQ-021 in_valid with in_ready=0 SHALL NOT modify any state.

Reset
REQ-022 On rst_n=0, stage valid flags SHALL clear immediately: out_valid=0, in_ready=1, sum=0, cout=0.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight results; the first valid after release SHALL appear exactly 2 cycles after acceptance.
REQ-024 Data registers SHALL also reset to 0 so that outputs are deterministic.

Configuration
REQ-025 With macro CLA_PIPE_OVF_EN defined, output port ovf (1 bit) SHALL exist, carrying signed overflow (carry into MSB XOR cout), registered alongside sum and reset to 0.
REQ-026 Without CLA_PIPE_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Shared package cla_pkg SHALL hold CLA_GROUP=4 and typedef pg_t (struct of P, G vectors).
REQ-028 Sub-module cla_group4 SHALL compute the four carries of one group from P[3:0], G[3:0] and cin; stage 2 SHALL instantiate it WIDTH/4 times.
REQ-029 The elaboration check SHALL reject WIDTH%4!=0.

Verification
REQ-030 Streaming: a=0x1234,b=0x4321,cin=0 at cycle 0, out_ready=1 -> sum=0x5555, cout=0, out_valid at cycle 2.
REQ-031 Carry chain: a=0xFFFF,b=0x0000,cin=1 -> sum=0x0000, cout=1; a=0x8000,b=0x8000,cin=0 -> sum=0x0000, cout=1 (ovf=1 with the macro defined).
REQ-032 Backpressure: 3 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready drops after 2 inputs are accepted, outputs are held stable, and all 3 results appear in order once ready rises.
REQ-033 Reset mid-flight: rst_n low for 1 cycle with 2 results in flight -> out_valid=0 immediately; no stale result after release.
REQ-034 Random: 10k random a/b/cin with random in_valid/out_ready -> every result matches the reference model a+b+cin, in order, with no loss or duplication.
REQ-035 WIDTH=4 instance: a=0xF,b=0x1,cin=0 -> sum=0x0, cout=1.
